// File: rtl/ex_issue_buffer_pkg.sv
// Shared shift-type and issue-buffer state encodings for the execute stage.
package ex_issue_buffer_pkg;

  localparam logic [1:0] SH_SRL  = 2'b00;
  localparam logic [1:0] SH_SLL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_PASS = 2'b11;

  localparam int SHAMT_W = 5;
  localparam int RD_W    = 5;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/ex_issue_buffer.sv
// Two-entry skid buffer between decode and the shifter; shamt resolved at push.
module ex_issue_buffer
  import ex_issue_buffer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_a,
  input  logic [XLEN-1:0]    in_b,
  input  logic               in_use_imm,
  input  logic [SHAMT_W-1:0] in_imm_shamt,
  input  logic [1:0]         in_type,
  input  logic [RD_W-1:0]    in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_a,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [1:0]         out_type,
  output logic [RD_W-1:0]    out_rd,
  output logic [1:0]         occupancy
);

  buf_state_e         state_r;
  logic [XLEN-1:0]    head_a_r, skid_a_r;
  logic [SHAMT_W-1:0] head_shamt_r, skid_shamt_r;
  logic [1:0]         head_type_r, skid_type_r;
  logic [RD_W-1:0]    head_rd_r, skid_rd_r;

  logic               push_s;
  logic               pop_s;
  logic [SHAMT_W-1:0] in_shamt_s;
  logic               unused_b_s;

  // Only the low shamt bits of the register operand matter here.
  assign unused_b_s = ^in_b[XLEN-1:SHAMT_W];

  // Handshake decode and shamt selection.
  always_comb begin
    in_ready   = (state_r != ST_TWO);
    out_valid  = (state_r != ST_EMPTY);
    push_s     = in_valid && in_ready;
    pop_s      = out_valid && out_ready;
    if (in_use_imm) begin
      in_shamt_s = in_imm_shamt;
    end else begin
      in_shamt_s = in_b[SHAMT_W-1:0];
    end
  end

  // State and payload registers; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      head_a_r     <= {XLEN{1'b0}};
      head_shamt_r <= {SHAMT_W{1'b0}};
      head_type_r  <= 2'b00;
      head_rd_r    <= {RD_W{1'b0}};
      skid_a_r     <= {XLEN{1'b0}};
      skid_shamt_r <= {SHAMT_W{1'b0}};
      skid_type_r  <= 2'b00;
      skid_rd_r    <= {RD_W{1'b0}};
    end else if (flush) begin
      state_r <= ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            head_a_r     <= in_a;
            head_shamt_r <= in_shamt_s;
            head_type_r  <= in_type;
            head_rd_r    <= in_rd;
            state_r      <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({push_s, pop_s})
            2'b10: begin
              skid_a_r     <= in_a;
              skid_shamt_r <= in_shamt_s;
              skid_type_r  <= in_type;
              skid_rd_r    <= in_rd;
              state_r      <= ST_TWO;
            end
            2'b01: state_r <= ST_EMPTY;
            2'b11: begin
              head_a_r     <= in_a;
              head_shamt_r <= in_shamt_s;
              head_type_r  <= in_type;
              head_rd_r    <= in_rd;
            end
            default: state_r <= ST_ONE;
          endcase
        end
        ST_TWO: begin
          if (pop_s) begin
            head_a_r     <= skid_a_r;
            head_shamt_r <= skid_shamt_r;
            head_type_r  <= skid_type_r;
            head_rd_r    <= skid_rd_r;
            state_r      <= ST_ONE;
          end
        end
        default: state_r <= ST_EMPTY;
      endcase
    end
  end

  assign out_a     = head_a_r;
  assign out_shamt = head_shamt_r;
  assign out_type  = head_type_r;
  assign out_rd    = head_rd_r;
  assign occupancy = state_r;

endmodule

// File: tb/tb_ex_issue_buffer.sv
// Directed self-checking bench for ex_issue_buffer.
module tb_ex_issue_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_use_imm, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_a;
  logic [4:0]  in_imm_shamt, in_rd, out_shamt, out_rd;
  logic [1:0]  in_type, out_type, occupancy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_issue_buffer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_use_imm(in_use_imm),
    .in_imm_shamt(in_imm_shamt), .in_type(in_type), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_shamt(out_shamt), .out_type(out_type), .out_rd(out_rd),
    .occupancy(occupancy)
  );

  // Reference shifter standing in for the downstream execute unit.
  function automatic logic [31:0] shift_ref(input logic [31:0] a, input logic [4:0] sh,
                                            input logic [1:0] t);
    case (t)
      2'b00:   return a >> sh;
      2'b01:   return a << sh;
      2'b10:   return $unsigned($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ui, input logic [4:0] imm, input logic [1:0] t,
                       input logic [4:0] rd);
    in_valid = v; in_a = a; in_b = b; in_use_imm = ui;
    in_imm_shamt = imm; in_type = t; in_rd = rd;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd0);
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_a", out_a, 32'd0);

    // SRA by register shamt, latency one cycle
    out_ready = 1'b1;
    drive(1'b1, 32'h80000000, 32'h00000004, 1'b0, 5'd9, 2'b10, 5'd5);
    step();
    in_valid = 1'b0;
    chk("sra_valid", {31'd0, out_valid}, 32'd1);
    chk("sra_shamt", {27'd0, out_shamt}, 32'd4);
    chk("sra_type", {30'd0, out_type}, 32'd2);
    chk("sra_result", shift_ref(out_a, out_shamt, out_type), 32'hF8000000);
    step();
    chk("sra_drain", {30'd0, occupancy}, 32'd0);

    // SLL by immediate shamt
    drive(1'b1, 32'h00000001, 32'h00000003, 1'b1, 5'd31, 2'b01, 5'd6);
    step();
    in_valid = 1'b0;
    chk("imm_shamt", {27'd0, out_shamt}, 32'd31);
    chk("imm_result", shift_ref(out_a, out_shamt, out_type), 32'h80000000);
    step();

    // Pass-through type carried untouched
    drive(1'b1, 32'h00001234, 32'h0000001F, 1'b0, 5'd0, 2'b11, 5'd7);
    step();
    in_valid = 1'b0;
    chk("pass_type", {30'd0, out_type}, 32'd3);
    chk("pass_a", out_a, 32'h00001234);
    chk("pass_shamt", {27'd0, out_shamt}, 32'd31);
    step();

    // Fill with out_ready low; third push blocked
    out_ready = 1'b0;
    drive(1'b1, 32'h00000011, 32'h0, 1'b0, 5'd0, 2'b00, 5'd1);
    step();
    chk("fill1_occ", {30'd0, occupancy}, 32'd1);
    drive(1'b1, 32'h00000022, 32'h0, 1'b0, 5'd0, 2'b00, 5'd2);
    step();
    chk("fill2_occ", {30'd0, occupancy}, 32'd2);
    chk("fill2_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h00000033, 32'h0, 1'b0, 5'd0, 2'b00, 5'd3);
    step();
    chk("block_occ", {30'd0, occupancy}, 32'd2);
    chk("block_ready", {31'd0, in_ready}, 32'd0);
    chk("block_rd", {27'd0, out_rd}, 32'd1);
    chk("block_a", out_a, 32'h00000011);
    out_ready = 1'b1;
    step();
    chk("drain_rd2", {27'd0, out_rd}, 32'd2);
    chk("drain_occ1", {30'd0, occupancy}, 32'd1);
    chk("drain_ready", {31'd0, in_ready}, 32'd1);
    step();
    // ONE with simultaneous push and pop
    in_valid = 1'b0;
    chk("pushpop_rd3", {27'd0, out_rd}, 32'd3);
    chk("pushpop_occ", {30'd0, occupancy}, 32'd1);
    chk("pushpop_a", out_a, 32'h00000033);
    step();
    chk("drain_empty", {30'd0, occupancy}, 32'd0);

    // Flush while full with a concurrent push
    out_ready = 1'b0;
    drive(1'b1, 32'h00000088, 32'h0, 1'b0, 5'd0, 2'b00, 5'd8);
    step();
    drive(1'b1, 32'h00000099, 32'h0, 1'b0, 5'd0, 2'b00, 5'd9);
    step();
    chk("preflush_occ", {30'd0, occupancy}, 32'd2);
    flush = 1'b1;
    drive(1'b1, 32'h000000AA, 32'h0, 1'b0, 5'd0, 2'b00, 5'd10);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("flush_nodrop", {31'd0, out_valid}, 32'd0);

    // Reset mid-transfer while full
    out_ready = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 32'h5, 1'b0, 5'd0, 2'b10, 5'd11);
    step();
    drive(1'b1, 32'hCAFEF00D, 32'h0, 1'b1, 5'd7, 2'b01, 5'd12);
    step();
    chk("prerst_occ", {30'd0, occupancy}, 32'd2);
    rst = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_occ", {30'd0, occupancy}, 32'd0);
    chk("rst2_ready", {31'd0, in_ready}, 32'd1);
    chk("rst2_a", out_a, 32'd0);
    chk("rst2_shamt", {27'd0, out_shamt}, 32'd0);
    chk("rst2_type", {30'd0, out_type}, 32'd0);
    chk("rst2_rd", {27'd0, out_rd}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
